// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding-select and hazard controller for a 5-stage pipeline.
//
// Tracks destination info for the instructions currently in EX (ex_q) and MEM
// (mem_q). Computes the EX-stage operand mux selects one cycle early, in ID, and
// registers them. Also detects load-use hazards and honours freeze and flush.
//
// Select encoding (mux4 inputs):
//   00 = register file
//   01 = EX/MEM ALU result
//   10 = MEM/WB write-back data
//   11 = immediate (operand B only)
//
// The register file is write-before-read, so an instruction three stages ahead
// needs no forwarding path.
module fwd_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              id_alu_src,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   input  logic              freeze,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              id_ex_bubble,
   output logic [1:0]        hz_state
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LU_STALL = 2'b01,
      FREEZE   = 2'b10
   } hz_state_e;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dest;
      logic              reg_write;
      logic              mem_read;
   } shadow_t;

   localparam logic [REG_AW-1:0] ZERO    = REG_AW'(ZERO_REG);
   localparam logic [1:0]        SEL_RF  = 2'b00;
   localparam logic [1:0]        SEL_EX  = 2'b01;
   localparam logic [1:0]        SEL_MEM = 2'b10;
   localparam logic [1:0]        SEL_IMM = 2'b11;

   hz_state_e state_q, state_d;
   shadow_t   ex_q, ex_d;
   shadow_t   mem_q, mem_d;
   logic [1:0] sel_a_q, sel_a_d;
   logic [1:0] sel_b_q, sel_b_d;

   logic       lu;
   logic [1:0] calc_a, calc_b;

   // A shadow entry is a forwarding source for r if it is a real instruction
   // that writes r, and r is not the hard-wired zero register.
   function automatic logic hit(input shadow_t s, input logic [REG_AW-1:0] r);
      return s.valid && s.reg_write && (s.dest == r) && (r != ZERO);
   endfunction

   // Select for one source operand. EX wins over MEM because it holds the
   // younger value.
   function automatic logic [1:0] src_sel(input shadow_t ex, input shadow_t mem,
                                          input logic [REG_AW-1:0] r);
      if (hit(ex, r))
         return SEL_EX;
      else if (hit(mem, r))
         return SEL_MEM;
      else
         return SEL_RF;
   endfunction

   // Load-use detection and the candidate selects for the instruction now in ID.
   always_comb begin
      lu = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != ZERO) &&
           ((ex_q.dest == id_rs) || (id_uses_rt && (ex_q.dest == id_rt)));
      calc_a = src_sel(ex_q, mem_q, id_rs);
      calc_b = id_alu_src ? SEL_IMM : src_sel(ex_q, mem_q, id_rt);
   end

   // Next-state, shadow/select updates and enables.
   // Priority order: freeze, then flush, then load-use, then normal advance.
   always_comb begin
      state_d        = state_q;
      ex_d           = ex_q;
      mem_d          = mem_q;
      sel_a_d        = sel_a_q;
      sel_b_d        = sel_b_q;
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      id_ex_bubble   = 1'b0;
      if (!rst_n) begin
         // Reset forces the idle enables even while other requests are asserted.
         state_d = RUN;
      end else if (freeze) begin
         // The whole pipeline holds: shadows and selects keep their values.
         state_d        = FREEZE;
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
      end else if (flush) begin
         // Kill the ID instruction. The PC stays enabled so the branch target
         // loads, even if a load-use hazard is pending.
         state_d      = RUN;
         id_ex_bubble = 1'b1;
         ex_d         = '0;
         mem_d        = ex_q;
         sel_a_d      = SEL_RF;
         sel_b_d      = SEL_RF;
      end else if (state_q == LU_STALL) begin
         // Dead cycle: the shadows hold so that the load stays in mem_q.
         // The held ID instruction is re-evaluated in RUN on the next cycle,
         // where it then resolves to the MEM/WB path.
         state_d        = RUN;
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_bubble   = 1'b1;
      end else if (lu) begin
         // Insert a bubble behind the load and hold the front end.
         state_d        = LU_STALL;
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_bubble   = 1'b1;
         ex_d           = '0;
         mem_d          = ex_q;
         sel_a_d        = SEL_RF;
         sel_b_d        = SEL_RF;
      end else begin
         // Normal advance. This path also covers the first cycle after a freeze
         // is released, so a pending hazard is re-checked there.
         state_d = RUN;
         ex_d    = '{valid: id_valid, dest: id_dest,
                     reg_write: id_reg_write, mem_read: id_mem_read};
         mem_d   = ex_q;
         sel_a_d = calc_a;
         sel_b_d = calc_b;
      end
   end

   // State, shadow and select registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         ex_q    <= '0;
         mem_q   <= '0;
         sel_a_q <= SEL_RF;
         sel_b_q <= SEL_RF;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

   assign fwd_a_sel = sel_a_q;
   assign fwd_b_sel = sel_b_q;
   assign hz_state  = state_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed, table-driven bench for fwd_hazard_ctrl.
// Inputs change 1 ns after posedge. Combinational enables are sampled at
// negedge; registered selects and state are sampled 1 ns after the next posedge.
module tb_fwd_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       id_alu_src;
   logic [4:0] id_dest;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       flush;
   logic       freeze;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       pc_write_en;
   logic       if_id_write_en;
   logic       id_ex_bubble;
   logic [1:0] hz_state;

   int n_chk  = 0;
   int n_pass = 0;

   fwd_hazard_ctrl #(.REG_AW(5), .ZERO_REG(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_alu_src(id_alu_src), .id_dest(id_dest),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .flush(flush), .freeze(freeze),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
      .id_ex_bubble(id_ex_bubble), .hz_state(hz_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   // One stimulus record: inputs for one cycle, the enables expected during
   // that cycle, and the selects/state expected after the following edge.
   typedef struct {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       ut;
      logic       as;
      logic [4:0] d;
      logic       rw;
      logic       mr;
      logic       fl;
      logic       fz;
      logic       pwe;
      logic       iwe;
      logic       bub;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] st;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic ut, input logic as, input logic [4:0] d,
                               input logic rw, input logic mr, input logic fl, input logic fz,
                               input logic pwe, input logic iwe, input logic bub,
                               input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] st);
      vec_t r;
      r.v = v;   r.rs = rs;   r.rt = rt;   r.ut = ut;   r.as = as;
      r.d = d;   r.rw = rw;   r.mr = mr;   r.fl = fl;   r.fz = fz;
      r.pwe = pwe; r.iwe = iwe; r.bub = bub;
      r.sa = sa; r.sb = sb; r.st = st;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic drive(input vec_t t);
      id_valid     = t.v;
      id_rs        = t.rs;
      id_rt        = t.rt;
      id_uses_rt   = t.ut;
      id_alu_src   = t.as;
      id_dest      = t.d;
      id_reg_write = t.rw;
      id_mem_read  = t.mr;
      flush        = t.fl;
      freeze       = t.fz;
   endtask

   task automatic run_vec(input vec_t t, input string tag);
      drive(t);
      @(negedge clk);
      chk({tag, " pc_write_en"},    8'(pc_write_en),    8'(t.pwe));
      chk({tag, " if_id_write_en"}, 8'(if_id_write_en), 8'(t.iwe));
      chk({tag, " id_ex_bubble"},   8'(id_ex_bubble),   8'(t.bub));
      @(posedge clk);
      #1;
      chk({tag, " fwd_a_sel"}, 8'(fwd_a_sel), 8'(t.sa));
      chk({tag, " fwd_b_sel"}, 8'(fwd_b_sel), 8'(t.sb));
      chk({tag, " hz_state"},  8'(hz_state),  8'(t.st));
   endtask

   vec_t tbl[23];
   vec_t idle;

   initial begin
      //       v  rs  rt ut as d  rw mr fl fz  pwe iwe bub  sa sb st
      tbl[0]  = mk(1, 1, 2, 1, 0, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0); // add r3
      tbl[1]  = mk(1, 3, 5, 1, 0, 4, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0); // sub r4,r3,r5
      tbl[2]  = mk(1, 3, 1, 1, 0, 6, 1, 0, 0, 0, 1, 1, 0, 2, 0, 0); // and r6,r3,r1
      tbl[3]  = mk(1, 6, 4, 1, 0, 7, 1, 0, 0, 0, 1, 1, 0, 1, 2, 0); // A from EX, B from MEM
      tbl[4]  = mk(1, 7, 6, 1, 0, 7, 1, 0, 0, 0, 1, 1, 0, 1, 2, 0);
      tbl[5]  = mk(1, 7, 7, 1, 0, 9, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0); // EX beats MEM
      tbl[6]  = mk(1, 9, 2, 0, 1, 2, 1, 1, 0, 0, 1, 1, 0, 1, 3, 0); // lw r2
      tbl[7]  = mk(1, 1, 2, 1, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1); // add r7,r1,r2: load-use
      tbl[8]  = mk(1, 1, 2, 1, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); // stall cycle
      tbl[9]  = mk(1, 1, 2, 1, 0, 7, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0); // re-evaluated: B=10
      tbl[10] = mk(1, 7, 3, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0); // writes r0
      tbl[11] = mk(1, 0, 0, 1, 0, 5, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0); // reads r0: no fwd
      tbl[12] = mk(1, 0, 6, 0, 1, 6, 1, 0, 0, 0, 1, 1, 0, 0, 3, 0); // addi: B=11
      tbl[13] = mk(1, 5, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 2, 3, 0); // lw r0
      tbl[14] = mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0); // r0 after load: no stall
      tbl[15] = mk(1, 1, 0, 0, 1, 4, 1, 1, 0, 0, 1, 1, 0, 1, 3, 0); // lw r4
      tbl[16] = mk(0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 3, 0); // id_valid=0: no stall
      tbl[17] = mk(1, 4, 0, 0, 1, 3, 1, 1, 0, 0, 1, 1, 0, 2, 3, 0); // lw r3
      tbl[18] = mk(1, 3, 0, 1, 0, 8, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0); // flush + load-use
      tbl[19] = mk(1, 3, 0, 1, 0, 8, 1, 0, 0, 0, 1, 1, 0, 2, 0, 0);
      tbl[20] = mk(1, 8, 0, 1, 0, 2, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0); // plain flush
      tbl[21] = mk(1, 8, 8, 1, 0, 2, 0, 0, 0, 0, 1, 1, 0, 2, 2, 0);
      tbl[22] = mk(1, 2, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); // reg_write=0: no fwd
      idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

      // Reset asserted mid-cycle, with freeze up to show that reset wins.
      rst_n = 1'b1;
      drive(idle);
      freeze = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset fwd_a_sel",      8'(fwd_a_sel),      8'd0);
      chk("reset fwd_b_sel",      8'(fwd_b_sel),      8'd0);
      chk("reset pc_write_en",    8'(pc_write_en),    8'd1);
      chk("reset if_id_write_en", 8'(if_id_write_en), 8'd1);
      chk("reset id_ex_bubble",   8'(id_ex_bubble),   8'd0);
      chk("reset hz_state",       8'(hz_state),       8'd0);
      freeze = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 23; i++)
         run_vec(tbl[i], $sformatf("row%0d", i));

      // Freeze held 3 cycles while in LU_STALL; flush is ignored under freeze.
      run_vec(mk(1, 1, 0, 0, 1, 2, 1, 1, 0, 0, 1, 1, 0, 0, 3, 0), "frz lw");
      run_vec(mk(1, 1, 2, 1, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1), "frz lu");
      run_vec(mk(1, 1, 2, 1, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2), "frz c1");
      run_vec(mk(1, 1, 2, 1, 0, 7, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2), "frz c2");
      run_vec(mk(1, 1, 2, 1, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2), "frz c3");
      run_vec(mk(1, 1, 2, 1, 0, 7, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0), "frz release");
      // Freeze from RUN holds nonzero selects.
      run_vec(mk(1, 7, 0, 1, 0, 2, 1, 1, 0, 1, 0, 0, 0, 0, 2, 2), "frz hold");
      run_vec(mk(1, 7, 0, 1, 0, 2, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0), "frz resume");

      // Reset asserted mid-cycle during a load-use stall clears everything.
      drive(mk(1, 2, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk("pre-rst pc_write_en", 8'(pc_write_en), 8'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid-rst fwd_a_sel",      8'(fwd_a_sel),      8'd0);
      chk("mid-rst pc_write_en",    8'(pc_write_en),    8'd1);
      chk("mid-rst if_id_write_en", 8'(if_id_write_en), 8'd1);
      chk("mid-rst id_ex_bubble",   8'(id_ex_bubble),   8'd0);
      chk("mid-rst hz_state",       8'(hz_state),       8'd0);
      drive(idle);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      // With the load shadow cleared, a reader of r2 neither stalls nor forwards.
      run_vec(mk(1, 2, 2, 1, 0, 5, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0), "post-rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
